lsu_ctrl: RTL and testbench

Multi-cycle load/store controller between the execute stage and the data-memory port, downstream of EXU and feeding writeback. It accepts one memory uop per valid/ready handshake and checks alignment. It then drives a req/gnt + rvalid memory interface with a lane-placed store mask, formats load data with byte/half select and sign or zero extension, and presents the result to writeback with a valid/ready handshake. Only one operation is in flight at a time.

---
 rtl/lsu_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store controller between EXU, data memory and writeback
// Alignment check, req/gnt + rvalid memory handshake, store lane placement and load extension.
module lsu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            in_is_load_i,
  input  logic            in_is_store_i,
  input  logic [1:0]      in_size_i,
  input  logic            in_unsigned_i,
  input  logic [XLEN-1:0] in_addr_i,
  input  logic [XLEN-1:0] in_wdata_i,
  input  logic [4:0]      in_rd_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [3:0]      mem_wmask_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [4:0]      out_rd_o,
  output logic            out_wen_o,
  output logic [XLEN-1:0] out_data_o,
  output logic            out_misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            is_store_q, is_store_d;
  logic [1:0]      size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [4:0]      rd_q, rd_d;
  logic            wen_q, wen_d;
  logic            misalign_q, misalign_d;

  logic            in_fault;
  logic            is_mem;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_fmt;
  logic [XLEN-1:0] store_lane;
  logic [3:0]      store_mask;

  assign is_mem   = in_is_load_i | in_is_store_i;
  assign in_fault = (in_size_i == 2'd3)
                  | ((in_size_i == 2'd1) & in_addr_i[0])
                  | ((in_size_i == 2'd2) & (|in_addr_i[1:0]));

  always_comb begin
    ld_byte  = mem_rdata_i[8*addr_q[1:0] +: 8];
    ld_half  = mem_rdata_i[16*addr_q[1] +: 16];
    load_fmt = mem_rdata_i;
    case (size_q)
      2'd0: load_fmt = unsigned_q ? {{(XLEN-8){1'b0}}, ld_byte}
                                  : {{(XLEN-8){ld_byte[7]}}, ld_byte};
      2'd1: load_fmt = unsigned_q ? {{(XLEN-16){1'b0}}, ld_half}
                                  : {{(XLEN-16){ld_half[15]}}, ld_half};
      default: load_fmt = mem_rdata_i;
    endcase
  end

  // Only byte/half/word reach REQ; reserved sizes fault before issuing.
  always_comb begin
    store_lane = wdata_q;
    store_mask = 4'b1111;
    case (size_q)
      2'd0: begin
        store_lane = {{(XLEN-8){1'b0}}, wdata_q[7:0]} << {addr_q[1:0], 3'b000};
        store_mask = 4'b0001 << addr_q[1:0];
      end
      2'd1: begin
        store_lane = {{(XLEN-16){1'b0}}, wdata_q[15:0]} << {addr_q[1], 4'b0000};
        store_mask = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: begin
        store_lane = wdata_q;
        store_mask = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    rd_d       = rd_q;
    wen_d      = wen_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_o) begin
          is_store_d = in_is_store_i;
          size_d     = in_size_i;
          unsigned_d = in_unsigned_i;
          addr_d     = in_addr_i;
          wdata_d    = in_wdata_i;
          rd_d       = in_rd_i;
          data_d     = '0;
          wen_d      = 1'b0;
          misalign_d = is_mem & in_fault;
          state_d    = (is_mem && !in_fault) ? REQ : RESP;
        end
      end
      REQ: begin
        if (mem_gnt_i) state_d = is_store_q ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          data_d  = load_fmt;
          wen_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      rd_q       <= 5'd0;
      wen_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      wen_q      <= wen_d;
      misalign_q <= misalign_d;
    end
  end

  assign in_ready_o     = (state_q == IDLE) && !rst_i;
  assign mem_req_o      = (state_q == REQ);
  assign mem_we_o       = mem_req_o & is_store_q;
  assign mem_addr_o     = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata_o    = mem_we_o ? store_lane : '0;
  assign mem_wmask_o    = mem_we_o ? store_mask : 4'b0000;
  assign out_valid_o    = (state_q == RESP);
  assign out_rd_o       = rd_q;
  assign out_wen_o      = wen_q;
  assign out_data_o     = data_q;
  assign out_misalign_o = misalign_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i, in_ready_o, in_is_load_i, in_is_store_i, in_unsigned_i;
  logic [1:0]  in_size_i;
  logic [31:0] in_addr_i, in_wdata_i;
  logic [4:0]  in_rd_i;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_wmask_o;
  logic        out_valid_o, out_ready_i, out_wen_o, out_misalign_o;
  logic [4:0]  out_rd_o;
  logic [31:0] out_data_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_is_load_i(in_is_load_i), .in_is_store_i(in_is_store_i),
    .in_size_i(in_size_i), .in_unsigned_i(in_unsigned_i),
    .in_addr_i(in_addr_i), .in_wdata_i(in_wdata_i), .in_rd_i(in_rd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_rd_o(out_rd_o),
    .out_wen_o(out_wen_o), .out_data_o(out_data_o), .out_misalign_o(out_misalign_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    in_valid_i = 1'b1; in_is_load_i = ld; in_is_store_i = st;
    in_size_i = size; in_unsigned_i = uns; in_addr_i = addr;
    in_wdata_i = wdata; in_rd_i = rd;
    #1;
    chk("in_ready_idle", {31'd0, in_ready_o}, 32'd1);
    step();
    in_valid_i = 1'b0; in_is_load_i = 1'b0; in_is_store_i = 1'b0;
    in_wdata_i = 32'h0; in_addr_i = 32'h0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [31:0] rdata, input logic [31:0] exp, input logic [4:0] rd);
    mem_gnt_i = 1'b1;
    issue(1'b1, 1'b0, size, uns, addr, 32'hFFFF_FFFF, rd);
    chk("ld_req", {31'd0, mem_req_o}, 32'd1);
    chk("ld_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
    chk("ld_we", {31'd0, mem_we_o}, 32'd0);
    chk("ld_wmask", {28'd0, mem_wmask_o}, 32'd0);
    chk("ld_valid_early1", {31'd0, out_valid_o}, 32'd0);
    step();
    mem_gnt_i = 1'b0;
    chk("ld_req_drop", {31'd0, mem_req_o}, 32'd0);
    chk("ld_valid_early2", {31'd0, out_valid_o}, 32'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    chk("ld_valid", {31'd0, out_valid_o}, 32'd1);
    chk("ld_data", out_data_o, exp);
    chk("ld_wen", {31'd0, out_wen_o}, 32'd1);
    chk("ld_misalign", {31'd0, out_misalign_o}, 32'd0);
    chk("ld_rd", {27'd0, out_rd_o}, {27'd0, rd});
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk("ld_valid_drop", {31'd0, out_valid_o}, 32'd0);
    chk("ld_ready_back", {31'd0, in_ready_o}, 32'd1);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_mask,
                          input int gnt_delay, input int hold);
    mem_gnt_i = 1'b0;
    issue(1'b0, 1'b1, size, 1'b0, addr, wdata, 5'd9);
    for (int i = 0; i <= gnt_delay; i++) begin
      if (i == gnt_delay) mem_gnt_i = 1'b1;
      chk("st_req", {31'd0, mem_req_o}, 32'd1);
      chk("st_we", {31'd0, mem_we_o}, 32'd1);
      chk("st_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
      chk("st_wdata", mem_wdata_o, exp_wdata);
      chk("st_wmask", {28'd0, mem_wmask_o}, {28'd0, exp_mask});
      chk("st_valid_early", {31'd0, out_valid_o}, 32'd0);
      step();
    end
    mem_gnt_i = 1'b0;
    for (int i = 0; i <= hold; i++) begin
      chk("st_req_drop", {31'd0, mem_req_o}, 32'd0);
      chk("st_valid", {31'd0, out_valid_o}, 32'd1);
      chk("st_wen", {31'd0, out_wen_o}, 32'd0);
      chk("st_misalign", {31'd0, out_misalign_o}, 32'd0);
      chk("st_data", out_data_o, 32'd0);
      chk("st_in_ready", {31'd0, in_ready_o}, 32'd0);
      if (i < hold) step();
    end
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk("st_valid_drop", {31'd0, out_valid_o}, 32'd0);
    chk("st_ready_back", {31'd0, in_ready_o}, 32'd1);
  endtask

  task automatic do_fault(input logic ld, input logic st, input logic [1:0] size,
                          input logic [31:0] addr, input logic exp_mis);
    mem_gnt_i = 1'b1;
    issue(ld, st, size, 1'b0, addr, 32'h1234_5678, 5'd3);
    chk("flt_no_req", {31'd0, mem_req_o}, 32'd0);
    chk("flt_valid", {31'd0, out_valid_o}, 32'd1);
    chk("flt_misalign", {31'd0, out_misalign_o}, {31'd0, exp_mis});
    chk("flt_wen", {31'd0, out_wen_o}, 32'd0);
    chk("flt_data", out_data_o, 32'd0);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    mem_gnt_i = 1'b0;
    chk("flt_valid_drop", {31'd0, out_valid_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; in_is_load_i = 1'b0; in_is_store_i = 1'b0;
    in_size_i = 2'd0; in_unsigned_i = 1'b0; in_addr_i = 32'h0; in_wdata_i = 32'h0;
    in_rd_i = 5'd0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    out_ready_i = 1'b0;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_wen", {31'd0, out_wen_o}, 32'd0);
    chk("rst_misalign", {31'd0, out_misalign_o}, 32'd0);
    chk("rst_data", out_data_o, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, in_ready_o}, 32'd1);
    step();

    do_load(32'h8000_0003, 2'd0, 1'b0, 32'h80AA_BBCC, 32'hFFFF_FF80, 5'd5);
    do_load(32'h8000_0002, 2'd1, 1'b1, 32'h9ABC_1234, 32'h0000_9ABC, 5'd6);
    do_load(32'h8000_0002, 2'd1, 1'b0, 32'h9ABC_1234, 32'hFFFF_9ABC, 5'd7);
    do_load(32'h8000_0000, 2'd1, 1'b0, 32'h9ABC_1234, 32'h0000_1234, 5'd8);
    do_load(32'h8000_0001, 2'd0, 1'b1, 32'h80AA_BBCC, 32'h0000_00BB, 5'd10);
    do_load(32'h8000_0008, 2'd2, 1'b0, 32'h1234_5678, 32'h1234_5678, 5'd31);

    do_store(32'h8000_0006, 2'd1, 32'h0000_BEEF, 32'hBEEF_0000, 4'b1100, 3, 5);
    do_store(32'h8000_0001, 2'd0, 32'h1234_5678, 32'h0000_7800, 4'b0010, 0, 0);
    do_store(32'h8000_000C, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 1, 0);

    do_fault(1'b1, 1'b0, 2'd2, 32'h8000_0001, 1'b1);
    do_fault(1'b0, 1'b1, 2'd3, 32'h8000_0000, 1'b1);
    do_fault(1'b1, 1'b0, 2'd1, 32'h8000_0003, 1'b1);
    do_fault(1'b0, 1'b0, 2'd2, 32'h8000_0001, 1'b0);

    // Abandon a load in WAIT; the late rvalid must not produce a result.
    mem_gnt_i = 1'b1;
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 5'd4);
    step();
    mem_gnt_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready_o}, 32'd0);
    step();
    rst_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80AA_BBCC;
    chk("midrst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
    step();
    mem_rvalid_i = 1'b0;
    chk("late_rvalid_valid", {31'd0, out_valid_o}, 32'd0);
    chk("late_rvalid_wen", {31'd0, out_wen_o}, 32'd0);
    chk("midrst_ready_back", {31'd0, in_ready_o}, 32'd1);
    step();
    chk("late_rvalid_valid2", {31'd0, out_valid_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
